// File: rtl/nco_freq_meas.sv
// Gated rising-edge counter that reports carrier frequency as an NCO phase increment.
// Optional macro NCO_FREQ_MEAS_SIGN_EN adds cos_in/dir_neg for signed (direction-aware) estimates.
module nco_freq_meas #(
  parameter int WIDTH       = 64,
  parameter int GATE_LOG2   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin_in,
`ifdef NCO_FREQ_MEAS_SIGN_EN
  input  logic                 cos_in,
  output logic                 dir_neg,
`endif
  input  logic                 start,
  input  logic                 cont_en,
  output logic                 busy,
  output logic                 meas_valid,
  output logic [GATE_LOG2-1:0] edge_count,
  output logic [WIDTH-1:0]     phase_inc_est
);

  localparam int SHIFT = WIDTH - GATE_LOG2;
  localparam logic [GATE_LOG2-1:0] CNT_ONE = {{(GATE_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sin_sync_q;
  logic                   sin_prev_q;
  logic [GATE_LOG2-1:0]   gate_q, gate_d;
  logic [GATE_LOG2-1:0]   run_q, run_d;
  logic [GATE_LOG2-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       est_q, est_d;
  logic [WIDTH-1:0]       est_mag;
  logic                   rise;
  logic                   dir_q, dir_d;
  logic                   dir_neg_q, dir_neg_d;
  logic                   cos_now;

  // Synchronizer MSB is the settled carrier; sin_prev_q is its one-cycle-old copy.
  assign rise = sin_sync_q[SYNC_STAGES-1] & ~sin_prev_q;

`ifdef NCO_FREQ_MEAS_SIGN_EN
  logic [SYNC_STAGES-1:0] cos_sync_q;

  always_ff @(posedge clk) begin
    if (rst) cos_sync_q <= '0;
    else     cos_sync_q <= {cos_sync_q[SYNC_STAGES-2:0], cos_in};
  end

  assign cos_now = cos_sync_q[SYNC_STAGES-1];
  assign dir_neg = dir_neg_q;
`else
  assign cos_now = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sin_sync_q <= '0;
      sin_prev_q <= 1'b0;
      gate_q     <= '0;
      run_q      <= '0;
      cnt_q      <= '0;
      est_q      <= '0;
      dir_q      <= 1'b1;
      dir_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sin_sync_q <= {sin_sync_q[SYNC_STAGES-2:0], sin_in};
      sin_prev_q <= sin_sync_q[SYNC_STAGES-1];
      gate_q     <= gate_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      est_q      <= est_d;
      dir_q      <= dir_d;
      dir_neg_q  <= dir_neg_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    est_d     = est_q;
    dir_d     = dir_q;
    dir_neg_d = dir_neg_q;
    est_mag   = '0;
    case (state_q)
      S_IDLE: begin
        if (start || cont_en) begin
          state_d = S_MEASURE;
          gate_d  = '0;
          run_d   = '0;
          dir_d   = 1'b1;
        end
      end
      S_MEASURE: begin
        gate_d = gate_q + CNT_ONE;
        if (rise) begin
          if (run_q != '1) run_d = run_q + CNT_ONE;
          dir_d = cos_now;
        end
        // Results latch on the last gate cycle so they are visible during DONE.
        if (gate_q == '1) begin
          state_d   = S_DONE;
          est_mag   = {run_d, {SHIFT{1'b0}}};
          cnt_d     = run_d;
          dir_neg_d = ~dir_d;
          est_d     = dir_d ? est_mag : -est_mag;
        end
      end
      S_DONE: begin
        if (cont_en) begin
          state_d = S_MEASURE;
          gate_d  = '0;
          run_d   = '0;
          dir_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign meas_valid    = (state_q == S_DONE);
  assign edge_count    = cnt_q;
  assign phase_inc_est = est_q;

endmodule

// File: doc/nco_freq_meas.md
Name: nco_freq_meas

Overview:
- Measures the frequency of an incoming 1-bit square carrier, such as the sine output of the team's NCO or an external comparator signal.
- Reports the result as the equivalent NCO phase increment, on the same WIDTH-bit scale used to program the NCO.
- Gated edge counter: counts rising edges of sin_in over 2^GATE_LOG2 clk cycles.
- Estimate is edge_count << (WIDTH-GATE_LOG2). No divider required.
- Used for loopback self-test of the NCO and for coarse carrier acquisition before tuning.

Parameters:
- WIDTH, 64, width of the phase-increment estimate; matches NCO accumulator width.
- GATE_LOG2, 16, log2 of the gate length in clk cycles; legal range 2..WIDTH-1.
- SYNC_STAGES, 2, number of flip-flops in the sin_in synchronizer; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sin_in  in  1  asynchronous square carrier to measure
- start  in  1  one-cycle request to begin a gate; sampled only in IDLE
- cont_en  in  1  when 1, a new gate starts automatically after each DONE
- busy  out  1  high in MEASURE and DONE
- meas_valid  out  1  one-cycle pulse; result outputs updated this cycle
- edge_count  out  GATE_LOG2  rising edges counted in the last completed gate
- phase_inc_est  out  WIDTH  edge_count zero-extended and shifted left by WIDTH-GATE_LOG2

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; busy=0; meas_valid=0; edge_count=0; phase_inc_est=0.
  - Synchronizer flops, edge-detect register and gate counter cleared.
  - Reset asserted mid-gate aborts the measurement; no meas_valid is produced.
- Synchronizer and edge detection:
  - sin_in passes through SYNC_STAGES flops, then one edge-detect register.
  - A rising edge is the synchronized value 1 while the previous value is 0.
  - Edge pulse trails the input transition by SYNC_STAGES+1 cycles. This is the accepted measurement skew.
- FSM states: IDLE, MEASURE, DONE.
  - IDLE: start=1 (or cont_en=1) moves to MEASURE next cycle. Gate counter and running edge counter are cleared on this transition.
  - MEASURE: lasts exactly 2^GATE_LOG2 cycles. Gate counter runs 0..2^GATE_LOG2-1.
    - An edge pulse in any MEASURE cycle, including the last, increments the running counter.
    - Edges in IDLE or DONE are not counted.
    - After the cycle with gate counter = all ones, moves to DONE.
  - DONE (one cycle):
    - edge_count and phase_inc_est are registered from the running counter; meas_valid=1.
    - Next state is MEASURE if cont_en=1 (counters cleared, so no dead gap beyond this one cycle), else IDLE.
- Latency: start accepted at cycle t → meas_valid at cycle t+1+2^GATE_LOG2.
- start while busy=1 is ignored; no queuing.
- Result outputs hold their value until the next DONE.
- Arithmetic:
  - At most one edge per 2 cycles, so maximum count is 2^(GATE_LOG2-1). GATE_LOG2 bits cannot overflow.
  - Running counter saturates at all ones anyway.
  - phase_inc_est = {edge_count, (WIDTH-GATE_LOG2) zeros}.
- Accuracy: estimate is within ±2^(WIDTH-GATE_LOG2) of the true increment (±1 edge quantization).

Optional Feature:
- Macro NCO_FREQ_MEAS_SIGN_EN.
- When defined:
  - Adds input port cos_in (1 bit), synchronized identically to sin_in.
  - On each counted sin edge, the synchronized cos value is captured into a direction register.
  - cos=1 means the phase is increasing; cos=0 means the phase is decreasing.
  - At DONE, if the last captured direction is 0, phase_inc_est is the two's-complement negation of the shifted count.
  - Adds output dir_neg (1 bit, reset 0), registered at DONE.
- When undefined: no cos_in or dir_neg ports; the estimate is always non-negative.

Test Plan (WIDTH=16, GATE_LOG2=8, SYNC_STAGES=2 unless stated):
- Reset, then idle 20 cycles with start=0 → busy=0, meas_valid=0, edge_count=0, phase_inc_est=0x0000.
- sin_in from an NCO model with increment 0x1000 (clk/16), start pulse at cycle t → meas_valid exactly at t+257; edge_count 15..17; phase_inc_est 0x0F00..0x1100.
- sin_in constant 0, then constant 1 → edge_count=0, phase_inc_est=0 for both gates.
- Toggle sin_in every cycle (increment 0x8000) → edge_count 127 or 128; phase_inc_est 0x7F00 or 0x8000; no wrap.
- cont_en=1 with increment 0x0400 → meas_valid every 257 cycles, each edge_count 3..5. Pulse start mid-gate → no effect. Assert rst at gate cycle 100 → no meas_valid; outputs return to 0.
- NCO_FREQ_MEAS_SIGN_EN defined, NCO model increment -0x1000 (0xF000) driving sin_in/cos_in → dir_neg=1, phase_inc_est 0xEF00..0xF100.
